// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: FSM states, cause indices
// and the cause-index width helper.
package exc_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_TAKEN,
        ST_HANDLER,
        ST_RETURN
    } exc_state_e;

    localparam int CAUSE_OVF   = 0;
    localparam int CAUSE_UNDEF = 1;
    localparam int CAUSE_EXT   = 2;
    localparam int CAUSE_SW    = 3;

    // A single cause still needs a one-bit index.
    function automatic int cause_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder: reports the index of the lowest set bit
// of vec, and whether any bit is set at all.
module exc_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan from the top down so that the last match, the lowest index, wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: latches cause requests, takes the highest-priority
// enabled one, redirects to the handler vector and back to EPC on eret.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                NUM_CAUSES  = 4,
    parameter logic [DATA_W-1:0] VECTOR_ADDR = DATA_W'(16'h0080),
    localparam int               CAUSE_W     = cause_width(NUM_CAUSES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [NUM_CAUSES-1:0] exc_req,
    input  logic                  mask_we,
    input  logic [NUM_CAUSES-1:0] mask_din,
    input  logic                  eret,
    output logic [DATA_W-1:0]     EPC,
    output logic [CAUSE_W-1:0]    Cause,
    output logic                  exc_taken,
    output logic                  redirect,
    output logic [DATA_W-1:0]     redirect_addr,
    output logic                  in_handler,
    output logic [NUM_CAUSES-1:0] pending
);

    exc_state_e            state;
    logic [NUM_CAUSES-1:0] mask;
    logic [NUM_CAUSES-1:0] eligible;
    logic [NUM_CAUSES-1:0] win_onehot;
    logic [CAUSE_W-1:0]    win_idx;
    logic                  win_valid;
    logic                  take;

    // Requests arriving this cycle compete alongside already-latched ones.
    assign eligible = (pending | exc_req) & mask;

    exc_prio_enc #(
        .N (NUM_CAUSES),
        .W (CAUSE_W)
    ) u_prio_enc (
        .vec   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign win_onehot = NUM_CAUSES'(1) << win_idx;
    assign take       = (state == ST_NORMAL) && win_valid;

    // Outputs are registered alongside the state so each one reflects the
    // state being entered at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_NORMAL;
            EPC           <= '0;
            Cause         <= '0;
            pending       <= '0;
            mask          <= '1;
            exc_taken     <= 1'b0;
            redirect      <= 1'b0;
            redirect_addr <= '0;
            in_handler    <= 1'b0;
        end else begin
            pending <= (pending | exc_req) & ~(take ? win_onehot : '0);
            if (mask_we) mask <= mask_din;

            case (state)
                ST_NORMAL: begin
                    if (win_valid) begin
                        state         <= ST_TAKEN;
                        EPC           <= pc_in;
                        Cause         <= win_idx;
                        exc_taken     <= 1'b1;
                        redirect      <= 1'b1;
                        redirect_addr <= VECTOR_ADDR;
                        in_handler    <= 1'b1;
                    end
                end
                ST_TAKEN: begin
                    state     <= ST_HANDLER;
                    exc_taken <= 1'b0;
                    redirect  <= 1'b0;
                end
                ST_HANDLER: begin
                    if (eret) begin
                        state         <= ST_RETURN;
                        redirect      <= 1'b1;
                        redirect_addr <= EPC;
                        in_handler    <= 1'b0;
                    end
                end
                ST_RETURN: begin
                    state    <= ST_NORMAL;
                    redirect <= 1'b0;
                end
                default: state <= ST_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: a per-cycle vector table feeding a scoreboard,
// plus a wide-parameter instance exercised by a short hand-written sequence.
module tb_exception_ctrl;
    import exc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] pc_in;
    logic [3:0]  exc_req;
    logic        mask_we;
    logic [3:0]  mask_din;
    logic        eret;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic        exc_taken;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        in_handler;
    logic [3:0]  pending;

    logic        rst_w;
    logic [31:0] pc_in_w;
    logic [7:0]  exc_req_w;
    logic        mask_we_w;
    logic [7:0]  mask_din_w;
    logic        eret_w;
    logic [31:0] epc_w;
    logic [2:0]  cause_w;
    logic        exc_taken_w;
    logic        redirect_w;
    logic [31:0] redirect_addr_w;
    logic        in_handler_w;
    logic [7:0]  pending_w;

    int checks = 0;
    int errors = 0;

    exception_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .exc_req       (exc_req),
        .mask_we       (mask_we),
        .mask_din      (mask_din),
        .eret          (eret),
        .EPC           (epc),
        .Cause         (cause),
        .exc_taken     (exc_taken),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .in_handler    (in_handler),
        .pending       (pending)
    );

    exception_ctrl #(
        .DATA_W     (32),
        .NUM_CAUSES (8)
    ) dut_wide (
        .clk           (clk),
        .rst           (rst_w),
        .pc_in         (pc_in_w),
        .exc_req       (exc_req_w),
        .mask_we       (mask_we_w),
        .mask_din      (mask_din_w),
        .eret          (eret_w),
        .EPC           (epc_w),
        .Cause         (cause_w),
        .exc_taken     (exc_taken_w),
        .redirect      (redirect_w),
        .redirect_addr (redirect_addr_w),
        .in_handler    (in_handler_w),
        .pending       (pending_w)
    );

    typedef struct {
        logic        rst;
        logic [15:0] pc;
        logic [3:0]  req;
        logic        mwe;
        logic [3:0]  mdin;
        logic        eret;
        logic        taken;
        logic        redir;
        logic [15:0] raddr;
        logic        inh;
        logic [15:0] epc;
        logic [1:0]  cause;
        logic [3:0]  pend;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t exp_v;

    function automatic vec_t mk(input logic rst_i, input logic [15:0] pc_i, input logic [3:0] req_i,
                                input logic mwe_i, input logic [3:0] mdin_i, input logic eret_i,
                                input logic taken_i, input logic redir_i, input logic [15:0] raddr_i,
                                input logic inh_i, input logic [15:0] epc_i, input int cause_i,
                                input logic [3:0] pend_i);
        vec_t v;
        v.rst = rst_i; v.pc = pc_i; v.req = req_i; v.mwe = mwe_i; v.mdin = mdin_i; v.eret = eret_i;
        v.taken = taken_i; v.redir = redir_i; v.raddr = raddr_i; v.inh = inh_i;
        v.epc = epc_i; v.cause = 2'(cause_i); v.pend = pend_i;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // redirect_addr is only meaningful while redirect is high, or right after reset.
    task automatic checkOutput(input vec_t e);
        checkVal("exc_taken", 32'(exc_taken), 32'(e.taken));
        checkVal("redirect", 32'(redirect), 32'(e.redir));
        checkVal("in_handler", 32'(in_handler), 32'(e.inh));
        checkVal("EPC", 32'(epc), 32'(e.epc));
        checkVal("Cause", 32'(cause), 32'(e.cause));
        checkVal("pending", 32'(pending), 32'(e.pend));
        if (e.redir || e.rst) checkVal("redirect_addr", 32'(redirect_addr), 32'(e.raddr));
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        pc_in    = v.pc;
        exc_req  = v.req;
        mask_we  = v.mwe;
        mask_din = v.mdin;
        eret     = v.eret;
        sb.push_back(v);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            checkOutput(exp_v);
        end
    end

    initial begin
        rst = 1'b0; pc_in = '0; exc_req = '0; mask_we = 1'b0; mask_din = '0; eret = 1'b0;
        rst_w = 1'b0; pc_in_w = '0; exc_req_w = '0; mask_we_w = 1'b0; mask_din_w = '0; eret_w = 1'b0;

        //            rst pc       req      mwe mdin     eret | tk rd raddr    inh epc      cause        pend
        vecs.push_back(mk(1, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'h0000, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 1,  0, 0, 16'h0000, 0, 16'h0000, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'hAB00, 4'b0001, 0, 4'b0000, 0,  1, 1, 16'h0080, 1, 16'hAB00, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'hAB00, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'hAB00, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 1,  0, 1, 16'hAB00, 0, 16'hAB00, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'hAB00, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h00CD, 4'b1010, 0, 4'b0000, 0,  1, 1, 16'h0080, 1, 16'h00CD, CAUSE_UNDEF, 4'b1000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'h00CD, CAUSE_UNDEF, 4'b1000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 1,  0, 1, 16'h00CD, 0, 16'h00CD, CAUSE_UNDEF, 4'b1000));
        vecs.push_back(mk(0, 16'h1234, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'h00CD, CAUSE_UNDEF, 4'b1000));
        vecs.push_back(mk(0, 16'h1234, 4'b0000, 0, 4'b0000, 0,  1, 1, 16'h0080, 1, 16'h1234, CAUSE_SW,    4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'h1234, CAUSE_SW,    4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0100, 0, 4'b0000, 1,  0, 1, 16'h1234, 0, 16'h1234, CAUSE_SW,    4'b0100));
        vecs.push_back(mk(0, 16'h5678, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'h1234, CAUSE_SW,    4'b0100));
        vecs.push_back(mk(0, 16'h5678, 4'b0000, 0, 4'b0000, 0,  1, 1, 16'h0080, 1, 16'h5678, CAUSE_EXT,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'h5678, CAUSE_EXT,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0001, 0, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'h5678, CAUSE_EXT,   4'b0001));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 1,  0, 1, 16'h5678, 0, 16'h5678, CAUSE_EXT,   4'b0001));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'h5678, CAUSE_EXT,   4'b0001));
        vecs.push_back(mk(0, 16'h9ABC, 4'b0000, 0, 4'b0000, 0,  1, 1, 16'h0080, 1, 16'h9ABC, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'h9ABC, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 1,  0, 1, 16'h9ABC, 0, 16'h9ABC, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'h9ABC, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 1, 4'b1110, 0,  0, 0, 16'h0000, 0, 16'h9ABC, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h1111, 4'b0001, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'h9ABC, CAUSE_OVF,   4'b0001));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'h9ABC, CAUSE_OVF,   4'b0001));
        vecs.push_back(mk(0, 16'h2222, 4'b0000, 1, 4'b1111, 0,  0, 0, 16'h0000, 0, 16'h9ABC, CAUSE_OVF,   4'b0001));
        vecs.push_back(mk(0, 16'h3333, 4'b0000, 0, 4'b0000, 0,  1, 1, 16'h0080, 1, 16'h3333, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'h3333, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0100, 1, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'h3333, CAUSE_OVF,   4'b0100));
        vecs.push_back(mk(1, 16'hFFFF, 4'b0010, 0, 4'b0000, 1,  0, 0, 16'h0000, 0, 16'h0000, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'h0000, CAUSE_OVF,   4'b0000));
        vecs.push_back(mk(0, 16'h4444, 4'b1000, 0, 4'b0000, 0,  1, 1, 16'h0080, 1, 16'h4444, CAUSE_SW,    4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 1,  0, 0, 16'h0000, 1, 16'h4444, CAUSE_SW,    4'b0000));
        vecs.push_back(mk(0, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 1, 16'h4444, CAUSE_SW,    4'b0000));
        vecs.push_back(mk(1, 16'h0000, 4'b0000, 0, 4'b0000, 0,  0, 0, 16'h0000, 0, 16'h0000, CAUSE_OVF,   4'b0000));

        $display("[TB] applying %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        checkVal("scoreboard_drained", 32'(sb.size()), 32'd0);

        @(negedge clk);
        rst = 1'b0; exc_req = '0; eret = 1'b0; mask_we = 1'b0;

        // Wide instance: cause 7 taken and full 32-bit PC captured.
        rst_w = 1'b1;
        @(posedge clk); #1;
        checkVal("wide_reset_EPC", epc_w, 32'h0);
        checkVal("wide_reset_pending", 32'(pending_w), 32'h0);
        @(negedge clk);
        rst_w = 1'b0; pc_in_w = 32'hDEADBEEF; exc_req_w = 8'h80;
        @(posedge clk); #1;
        checkVal("wide_exc_taken", 32'(exc_taken_w), 32'h1);
        checkVal("wide_Cause", 32'(cause_w), 32'h7);
        checkVal("wide_EPC", epc_w, 32'hDEADBEEF);
        checkVal("wide_redirect_addr", redirect_addr_w, 32'h00000080);
        checkVal("wide_pending", 32'(pending_w), 32'h0);
        @(negedge clk);
        exc_req_w = 8'h00; pc_in_w = 32'h0;
        @(posedge clk); #1;
        checkVal("wide_in_handler", 32'(in_handler_w), 32'h1);
        checkVal("wide_exc_taken_drop", 32'(exc_taken_w), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, width of PC and EPC.
REQ-002 Parameter NUM_CAUSES, default 4, number of exception sources; CAUSE_W = max(1, clog2(NUM_CAUSES)).
REQ-003 Parameter VECTOR_ADDR, default 16'h0080 (DATA_W wide), handler entry address.
REQ-004 Reset behaviour SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 pc_in  in  DATA_W  PC of instruction currently at exception point.
REQ-008 exc_req  in  NUM_CAUSES  per-cause request pulses, bit i = cause i.
REQ-009 mask_we  in  1  write enable for cause mask.
REQ-010 mask_din  in  NUM_CAUSES  new mask, 1 = cause enabled.
REQ-011 eret  in  1  return-from-exception strobe.
REQ-012 EPC  out  DATA_W  saved PC of the faulting instruction.
REQ-013 Cause  out  CAUSE_W  encoded index of the cause taken.
REQ-014 exc_taken  out  1  one-cycle pulse when an exception is accepted.
REQ-015 redirect  out  1  one-cycle pipeline flush/PC-redirect strobe.
REQ-016 redirect_addr  out  DATA_W  redirect target, valid when redirect = 1.
REQ-017 in_handler  out  1  high while in TAKEN or HANDLER.
REQ-018 pending  out  NUM_CAUSES  latched, not-yet-serviced requests.

Function
REQ-019 FSM states NORMAL, TAKEN, HANDLER, RETURN; registered outputs only.
REQ-020 Every exc_req bit SHALL be OR-ed into pending at each edge, regardless of state or mask.
REQ-021 Eligible set = (pending | exc_req) & mask; priority = lowest index wins.
REQ-022 NORMAL with eligible set non-zero: next state TAKEN; EPC <= pc_in; Cause <= winning index; winning pending bit cleared at that same edge.
REQ-023 TAKEN (exactly one cycle): exc_taken = 1, redirect = 1, redirect_addr = VECTOR_ADDR; next state HANDLER.
REQ-024 HANDLER: holds until eret = 1; new requests only latch into pending (no nesting); EPC/Cause unchanged.
REQ-025 HANDLER with eret = 1: next state RETURN.
REQ-026 RETURN (exactly one cycle): redirect = 1, redirect_addr = EPC; next state NORMAL.
REQ-027 Pending eligible requests are taken no earlier than the first NORMAL cycle after RETURN (latency ≥ 1 NORMAL cycle).
REQ-028 eret outside HANDLER SHALL be ignored.
REQ-029 Masked causes remain in pending; taken once unmasked by mask_we.
REQ-030 mask_we takes effect at the edge it is sampled; the new mask applies from the following cycle.
REQ-031 Latency exc_req edge -> exc_taken high: 1 cycle.
REQ-032 Simultaneous eret and exc_req in HANDLER: eret honoured, request latched.
REQ-033 Multiple simultaneous causes: highest priority taken, others stay pending.

Reset
REQ-034 rst SHALL force state NORMAL, EPC = 0, Cause = 0, pending = 0, mask = all ones, exc_taken = redirect = in_handler = 0, redirect_addr = 0.
REQ-035 rst mid-handler SHALL abandon the exception, with no redirect issued.
REQ-036 rst has priority over all other inputs in the same cycle.

Structure
REQ-037 Shared package exc_pkg SHALL hold the FSM state enum and named cause-index constants (CAUSE_OVF=0, CAUSE_UNDEF=1, CAUSE_EXT=2, CAUSE_SW=3).
REQ-038 Sub-module exc_prio_enc SHALL implement the parametrised lowest-index priority encoder (vector in; index and valid out).

Verification
REQ-039 Single request: pc_in=16'hAB00, exc_req=4'b0001 -> next cycle exc_taken=1, EPC=AB00, Cause=0, redirect_addr=0080; then HANDLER.
REQ-040 Priority: exc_req=4'b1010, pc_in=16'h00CD -> Cause=1, pending=4'b1000 afterward; after eret, RETURN redirects to 00CD, then Cause=3 is taken.
REQ-041 Mask: mask_din=4'b1110 with exc_req=4'b0001 -> no exc_taken, pending=4'b0001; mask_din=4'b1111 -> taken next cycle, Cause=0.
REQ-042 eret while NORMAL -> no redirect and no state change; eret plus exc_req[2] in HANDLER -> RETURN, then Cause=2 taken.
REQ-043 rst asserted in HANDLER with pending=4'b0100 -> all outputs at reset values, no redirect, pending=0.
REQ-044 Parameter sweep DATA_W=32, NUM_CAUSES=8, request on bit 7 -> Cause=3'd7, EPC captures full 32-bit pc_in.
